// File: rtl/score_bank_ctrl.sv
// Score-bank controller: stores per-round scores and schedules the shared score display between live play and a timed review replay.
// Build option: define SCORE_BANK_WRAP_EN to let writes into a full bank overwrite the oldest entry.
module score_bank_ctrl #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2,
    parameter int DWELL  = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic              review,
    input  logic [DATA_W-1:0] live_val,
    output logic [DATA_W-1:0] disp_val,
    output logic [3:0]        disp_tag,
    output logic              disp_blank,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              wr_drop
);

    typedef enum logic [1:0] {
        S_LIVE   = 2'd0,
        S_REVIEW = 2'd1,
        S_EMPTY  = 2'd2
    } state_t;

    localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [IDX_W:0]    DEPTH_CNT  = (IDX_W + 1)'(DEPTH);
    localparam logic [3:0]        TAG_BASE   = 4'd10;

`ifdef SCORE_BANK_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return p + IDX_W'(1);
    endfunction

    function automatic logic [IDX_W:0] count_sat_inc(input logic [IDX_W:0] c);
        return (c >= DEPTH_CNT) ? DEPTH_CNT : c + (IDX_W + 1)'(1);
    endfunction

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   wp_q, wp_d;
    logic [IDX_W-1:0]   op_q, op_d;
    logic [IDX_W-1:0]   ri_q, ri_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic               review_q;
    logic [DATA_W-1:0]  bank_q [DEPTH];

    logic               wr_acc;
    logic               drop_d;
    logic               full_d;
    logic [DATA_W-1:0]  val_d;
    logic [3:0]         tag_d;
    logic               blank_d;
    logic [IDX_W-1:0]   ri_off;
    logic [IDX_W-1:0]   tag_idx;
    logic [IDX_W:0]     ri_next_off;

    logic [DATA_W-1:0]  val_q;
    logic [3:0]         tag_q;
    logic               blank_q;
    logic               full_q;
    logic               drop_q;

    assign ri_off      = ri_q - op_q;
    assign ri_next_off = {1'b0, ri_off} + (IDX_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        op_d    = op_q;
        ri_d    = ri_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        wr_acc  = 1'b0;
        drop_d  = 1'b0;
        tag_idx = '0;

        if (clear) begin
            // A same-cycle write is discarded without a drop pulse.
            wp_d    = '0;
            op_d    = '0;
            ri_d    = '0;
            cnt_d   = '0;
            dwell_d = '0;
            state_d = review ? S_EMPTY : S_LIVE;
        end else begin
            if (wr_en) begin
                if (state_q == S_LIVE && (!full_q || WRAP_EN)) begin
                    wr_acc = 1'b1;
                    wp_d   = ptr_inc(wp_q);
                    if (full_q) begin
                        op_d = ptr_inc(op_q);
                    end else begin
                        cnt_d = count_sat_inc(cnt_q);
                    end
                end else begin
                    drop_d = 1'b1;
                end
            end

            unique case (state_q)
                S_LIVE: begin
                    // Use post-write count/op so a same-cycle write joins the replay.
                    if (review && !review_q) begin
                        if (cnt_d != '0) begin
                            state_d = S_REVIEW;
                            ri_d    = op_d;
                            dwell_d = '0;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end
                S_REVIEW: begin
                    if (!review) begin
                        state_d = S_LIVE;
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                        ri_d    = (ri_next_off >= cnt_q) ? op_q : ptr_inc(ri_q);
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
                S_EMPTY: begin
                    if (!review) begin
                        state_d = S_LIVE;
                    end
                end
                default: state_d = S_LIVE;
            endcase
        end

        full_d  = (cnt_d == DEPTH_CNT);
        val_d   = live_val;
        tag_d   = TAG_BASE + 4'(wp_d);
        blank_d = 1'b0;
        unique case (state_d)
            S_REVIEW: begin
                tag_idx = ri_d - op_d;
                tag_d   = TAG_BASE + 4'(tag_idx);
                val_d   = (wr_acc && wp_q == ri_d) ? wr_data : bank_q[ri_d];
            end
            S_EMPTY: begin
                val_d   = '0;
                tag_d   = TAG_BASE;
                blank_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_LIVE;
            wp_q     <= '0;
            op_q     <= '0;
            ri_q     <= '0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            review_q <= 1'b0;
            val_q    <= '0;
            tag_q    <= TAG_BASE;
            blank_q  <= 1'b0;
            full_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            op_q     <= op_d;
            ri_q     <= ri_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            review_q <= review;
            val_q    <= val_d;
            tag_q    <= tag_d;
            blank_q  <= blank_d;
            full_q   <= full_d;
            drop_q   <= drop_d;
        end
    end

    // Score storage carries no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            bank_q[wp_q] <= wr_data;
        end
    end

    assign disp_val   = val_q;
    assign disp_tag   = tag_q;
    assign disp_blank = blank_q;
    assign count      = cnt_q;
    assign full       = full_q;
    assign wr_drop    = drop_q;

endmodule
